ahb_lsu_master: RTL and testbench
=================================

# ahb_lsu_master

Single-master AHB-Lite front end between the RISC-V pipeline's load/store unit and the system bus. Converts one LSU request at a time into an AHB-Lite SINGLE transfer and decodes the address to the RAM slave or the AHB-APB-UART bridge. It also muxes the slave responses and returns sign- or zero-extended load data, or an error, to the pipeline.

## Interface
- `RAM_REGION`, 4'h0: HADDR[31:28] value selecting the RAM slave.
- `UART_REGION`, 4'h4: HADDR[31:28] value selecting the AHB-APB-UART bridge.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `lsu_req_i` in 1: request valid.
- `lsu_we_i` in 1: 1 = store, 0 = load.
- `lsu_addr_i` in 32: byte address.
- `lsu_wdata_i` in 32: store data, LSB-aligned.
- `lsu_size_i` in 2: 0 = byte, 1 = half, 2 = word (3 is illegal and is treated as misaligned).
- `lsu_unsigned_i` in 1: zero-extend the load result.
- `lsu_ready_o` out 1: request accepted when `lsu_req_i & lsu_ready_o`.
- `lsu_valid_o` out 1: one-cycle response strobe.
- `lsu_rdata_o` out 32: extended load data (0 for stores).
- `lsu_err_o` out 1: response is an error; qualified by `lsu_valid_o`.
- `HADDR` out 32, `HWRITE` out 1, `HSIZE` out 3, `HBURST` out 3 (always 3'b000), `HTRANS` out 2, `HWDATA` out 32: AHB master signals.
- `HSEL_RAM` out 1, `HSEL_UART` out 1: slave selects.
- `HREADY` out 1: bus-wide HREADY, fed back to the slaves' HREADY inputs.
- `HRDATA_RAM` in 32, `HREADYOUT_RAM` in 1: RAM response (RAM is always OKAY).
- `HRDATA_UART` in 32, `HREADYOUT_UART` in 1, `HRESP_UART` in 2: bridge response; bit0 = ERROR.

## Operation
- FSM states: IDLE, ADDR, DATA, FAULT.
- IDLE:
  - `lsu_ready_o`=1.
  - On accept with an aligned, mapped request: register HADDR, HWRITE, HSIZE = {1'b0, size} and the slave select; set HTRANS=NONSEQ; go to ADDR.
  - On accept with a misaligned (half with addr[0]=1; word with addr[1:0]≠0; size 3) or unmapped request: no bus transfer; go to FAULT.
- ADDR:
  - Address phase; HTRANS=NONSEQ for exactly this cycle.
  - At the edge: HTRANS→IDLE, HSEL_*→0; HWDATA driven from the registered store data; capture the data-phase select `dsel`; go to DATA.
- HWDATA byte replication by size:
  - byte: {4{b}}
  - half: {2{h}}
  - word: unchanged
- DATA:
  - Wait while HREADY=0.
  - On HREADY=1: register the response; `lsu_err_o` = (dsel==UART) & HRESP_UART[0]; go to IDLE with `lsu_valid_o`=1 for the next cycle.
- FAULT: one cycle; next cycle `lsu_valid_o`=1, `lsu_err_o`=1, `lsu_rdata_o`=0; go to IDLE.
- Read extract:
  - Lane selected by the registered HADDR[1:0] (byte) or HADDR[1] (half).
  - Sign-extended unless `lsu_unsigned_i` was set at accept. The unsigned flag is registered.
  - Stores return rdata 0.
- HREADY mux:
  - dsel RAM → HREADYOUT_RAM.
  - dsel UART → HREADYOUT_UART.
  - No data phase → 1.
- HRDATA mux selected by dsel.
- Two-cycle ERROR response from the UART bridge: first cycle HREADY=0, still waiting; completion sampled on the second cycle (HREADY=1, HRESP[0]=1) → error.
- HRESP_UART is ignored when dsel ≠ UART.

## Timing
- Reset values:
  - HTRANS=IDLE, all other AHB outputs 0, HREADY=1.
  - `lsu_ready_o`=1 the cycle after reset deasserts; it is 0 while `rst_i`=1.
  - `lsu_valid_o`/`lsu_err_o`/`lsu_rdata_o`=0; state IDLE.
- Zero-wait-state latency:
  - Accept edge E0; ADDR cycle E0→E1; DATA cycle E1→E2 completes.
  - `lsu_valid_o` high in the cycle after E2.
  - Each HREADY=0 cycle adds one cycle.
- FAULT latency: `lsu_valid_o` two cycles after the accept edge; HTRANS never leaves IDLE.
- `lsu_valid_o` and `lsu_ready_o` are both high in the response cycle. A request presented then is accepted, giving back-to-back throughput of one transfer per 3 cycles at zero wait.
- Exactly one outstanding transfer: no pipelined address phase overlapping a data phase.
- `lsu_*` inputs are sampled only at the accept edge; later changes have no effect.
- `rst_i` mid-transfer: the next cycle is in reset state, no `lsu_valid_o` is produced for the abandoned request, and HREADY returns to 1 immediately regardless of slave HREADYOUT.

## Test plan
- Word store then load, zero wait: store 0xDEADBEEF to 0x0000_0010, then load it.
  - Store: HTRANS=2'b10 for 1 cycle with HSEL_RAM=1 and HSIZE=3'b010; HWDATA=0xDEADBEEF in the data phase.
  - Load: returns 0xDEADBEEF, `lsu_valid_o` 3 cycles after the accept edge, err=0.
- Byte load from 0x0000_0013 with HRDATA_RAM=0x80xxxxxx:
  - signed → 0xFFFFFF80
  - unsigned → 0x00000080
  - half from 0x0000_0012 with HRDATA_RAM=0x8001xxxx, signed → 0xFFFF8001
- UART write to 0x4000_0000 with HREADYOUT_UART low for 3 cycles:
  - HREADY out tracks it and the FSM holds DATA.
  - `lsu_valid_o` 6 cycles after accept; HSEL_UART=1 in the address phase only.
- UART two-cycle ERROR (HRESP_UART[0]=1; HREADYOUT_UART=0 then 1) → `lsu_valid_o`=1, `lsu_err_o`=1.
- Misaligned word load at 0x0000_0002 and unmapped load at 0x8000_0000 → HTRANS stays IDLE, no HSEL asserted, err response 2 cycles after accept, rdata=0.
- `rst_i` asserted in the DATA cycle while HREADYOUT_RAM=0 → next cycle HTRANS=IDLE and HREADY=1, no `lsu_valid_o`, `lsu_ready_o`=1 after release.

Source files
------------

// File: rtl/ahb_lsu_master_if.sv
// LSU request/response and AHB-Lite bus bundle for the single-master LSU front end.
// master = the front end's view, slave = the pipeline/slave-side environment.
interface ahb_lsu_master_if;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_unsigned_i;
  logic        lsu_ready_o;
  logic        lsu_valid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;

  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HSEL_RAM;
  logic        HSEL_UART;
  logic        HREADY;
  logic [31:0] HRDATA_RAM;
  logic        HREADYOUT_RAM;
  logic [31:0] HRDATA_UART;
  logic        HREADYOUT_UART;
  logic [1:0]  HRESP_UART;

  modport master (
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_size_i, lsu_unsigned_i,
    output lsu_ready_o, lsu_valid_o, lsu_rdata_o, lsu_err_o,
    output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HSEL_RAM, HSEL_UART, HREADY,
    input  HRDATA_RAM, HREADYOUT_RAM, HRDATA_UART, HREADYOUT_UART, HRESP_UART
  );

  modport slave (
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_size_i, lsu_unsigned_i,
    input  lsu_ready_o, lsu_valid_o, lsu_rdata_o, lsu_err_o,
    input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HSEL_RAM, HSEL_UART, HREADY,
    output HRDATA_RAM, HREADYOUT_RAM, HRDATA_UART, HREADYOUT_UART, HRESP_UART
  );
endinterface

// File: rtl/ahb_lsu_master.sv
// AHB-Lite single-transfer front end for the LSU: decodes RAM/UART regions, runs one
// SINGLE transfer at a time and returns extended load data or an error.
module ahb_lsu_master #(
  parameter logic [3:0] RAM_REGION  = 4'h0,
  parameter logic [3:0] UART_REGION = 4'h4
) (
  input logic              clk_i,
  input logic              rst_i,
  ahb_lsu_master_if.master bus
);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FAULT} state_t;
  state_t state, state_nxt;

  logic        ready, hready, accept, misaligned, hit_ram, hit_uart;
  logic [31:0] haddr, hwdata, wdata_q, hrdata, rdata_ext, rdata, repl;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite, hsel_ram, hsel_uart, dsel_ram, dsel_uart, uns_q;
  logic        valid, err;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic        unused_resp;

  assign unused_resp = bus.HRESP_UART[1];

  assign hit_ram    = bus.lsu_addr_i[31:28] == RAM_REGION;
  assign hit_uart   = bus.lsu_addr_i[31:28] == UART_REGION;
  assign misaligned = (bus.lsu_size_i == 2'd3) ||
                      (bus.lsu_size_i == 2'd1 && bus.lsu_addr_i[0]) ||
                      (bus.lsu_size_i == 2'd2 && |bus.lsu_addr_i[1:0]);
  assign accept     = bus.lsu_req_i && ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (misaligned || !(hit_ram || hit_uart)) ? FAULT : ADDR;
      ADDR:  state_nxt = DATA;
      DATA:  if (hready) state_nxt = IDLE;
      FAULT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // HREADY only follows a slave while that slave owns the data phase; reset drops it at once.
  always_comb begin
    ready  = (state == IDLE) && !rst_i;
    hready = 1'b1;
    if (state == DATA) begin
      if (dsel_ram)       hready = bus.HREADYOUT_RAM;
      else if (dsel_uart) hready = bus.HREADYOUT_UART;
    end
    hrdata = dsel_uart ? bus.HRDATA_UART : bus.HRDATA_RAM;
    lane8  = 8'(hrdata >> {haddr[1:0], 3'b000});
    lane16 = 16'(hrdata >> {haddr[1], 4'b0000});
    case (hsize[1:0])
      2'd0:    rdata_ext = uns_q ? {24'b0, lane8}  : {{24{lane8[7]}}, lane8};
      2'd1:    rdata_ext = uns_q ? {16'b0, lane16} : {{16{lane16[15]}}, lane16};
      default: rdata_ext = hrdata;
    endcase
    if (hwrite) rdata_ext = 32'b0;
    case (hsize[1:0])
      2'd0:    repl = {4{wdata_q[7:0]}};
      2'd1:    repl = {2{wdata_q[15:0]}};
      default: repl = wdata_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      haddr <= '0; hwrite <= 1'b0; hsize <= '0; htrans <= HTRANS_IDLE; hwdata <= '0;
      hsel_ram <= 1'b0; hsel_uart <= 1'b0; dsel_ram <= 1'b0; dsel_uart <= 1'b0;
      wdata_q <= '0; uns_q <= 1'b0; valid <= 1'b0; err <= 1'b0; rdata <= '0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: if (accept) begin
          wdata_q <= bus.lsu_wdata_i;
          uns_q   <= bus.lsu_unsigned_i;
          if (state_nxt == ADDR) begin
            haddr     <= bus.lsu_addr_i;
            hwrite    <= bus.lsu_we_i;
            hsize     <= {1'b0, bus.lsu_size_i};
            htrans    <= HTRANS_NONSEQ;
            hsel_ram  <= hit_ram;
            hsel_uart <= hit_uart;
          end
        end
        ADDR: begin
          htrans    <= HTRANS_IDLE;
          hsel_ram  <= 1'b0;
          hsel_uart <= 1'b0;
          dsel_ram  <= hsel_ram;
          dsel_uart <= hsel_uart;
          hwdata    <= repl;
        end
        DATA: if (hready) begin
          valid     <= 1'b1;
          err       <= dsel_uart && bus.HRESP_UART[0];
          rdata     <= rdata_ext;
          dsel_ram  <= 1'b0;
          dsel_uart <= 1'b0;
        end
        FAULT: begin
          valid <= 1'b1;
          err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.lsu_ready_o = ready;
  assign bus.lsu_valid_o = valid;
  assign bus.lsu_err_o   = err;
  assign bus.lsu_rdata_o = rdata;
  assign bus.HADDR       = haddr;
  assign bus.HWRITE      = hwrite;
  assign bus.HSIZE       = hsize;
  assign bus.HBURST      = 3'b000;
  assign bus.HTRANS      = htrans;
  assign bus.HWDATA      = hwdata;
  assign bus.HSEL_RAM    = hsel_ram;
  assign bus.HSEL_UART   = hsel_uart;
  assign bus.HREADY      = hready;
endmodule

// File: tb/tb_ahb_lsu_master.sv
// Random + directed bench for ahb_lsu_master: byte-level RAM model, UART stub with wait
// states and two-cycle ERROR, and a byte-addressed reference memory for expected loads.
module tb_ahb_lsu_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  ahb_lsu_master_if bus ();
  ahb_lsu_master dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [7:0] i);
    return 8'((i * 29 + 7) ^ 8'h5A);
  endfunction

  // Slave side: RAM with byte lanes decoded from HSIZE/HADDR, UART stub returning uart_val.
  int          cfg_waits = 0;
  bit          cfg_err   = 1'b0;
  logic [31:0] uart_val  = '0;
  logic [7:0]  slv_mem [256];
  bit          written [256];
  bit          dph, dph_wr, dph_ram, dph_err;
  logic [31:0] dph_addr = '0;
  logic [1:0]  dph_size = '0;
  int          wcnt = 0;

  function automatic logic [7:0] rd(input logic [7:0] i);
    return written[i] ? slv_mem[i] : init_byte(i);
  endfunction

  always @(posedge clk) begin
    if (bus.HREADY) begin
      if (dph && dph_wr && dph_ram)
        for (int b = 0; b < 4; b++)
          if (dph_size == 2'd2 || (dph_size == 2'd1 && b[1] == dph_addr[1]) ||
              (dph_size == 2'd0 && b[1:0] == dph_addr[1:0])) begin
            slv_mem[{dph_addr[7:2], 2'(b)}] <= bus.HWDATA[8*b +: 8];
            written[{dph_addr[7:2], 2'(b)}] <= 1'b1;
          end
      dph      <= (bus.HTRANS == 2'b10) && (bus.HSEL_RAM || bus.HSEL_UART);
      dph_addr <= bus.HADDR;
      dph_size <= bus.HSIZE[1:0];
      dph_wr   <= bus.HWRITE;
      dph_ram  <= bus.HSEL_RAM;
      dph_err  <= cfg_err;
      wcnt     <= cfg_waits;
    end else if (wcnt > 0) begin
      wcnt <= wcnt - 1;
    end
  end

  always_comb begin
    bus.HRDATA_RAM = {rd({dph_addr[7:2], 2'd3}), rd({dph_addr[7:2], 2'd2}),
                      rd({dph_addr[7:2], 2'd1}), rd({dph_addr[7:2], 2'd0})};
  end
  assign bus.HRDATA_UART    = uart_val;
  assign bus.HREADYOUT_RAM  = !(dph && dph_ram && wcnt != 0);
  assign bus.HREADYOUT_UART = !(dph && !dph_ram && wcnt != 0);
  assign bus.HRESP_UART     = {1'b0, dph && !dph_ram && dph_err && wcnt <= 1};

  // Reference memory: stores place LSB-aligned data at consecutive byte addresses.
  logic [7:0] ref_mem [256];

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input int waits, input logic uerr);
    logic [31:0] word, v, exp_rd, exp_wd;
    logic        fault, is_ram, is_uart, got;
    int          nb, n, nonseq, selcnt;
    is_ram  = addr[31:28] == 4'h0;
    is_uart = addr[31:28] == 4'h4;
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    fault   = (size == 2'd3) || (addr % nb != 0) || !(is_ram || is_uart);
    uart_val  = $urandom;
    cfg_waits = waits;
    cfg_err   = uerr;
    exp_rd    = '0;
    if (!fault && !we) begin
      word = is_ram ? {ref_mem[{addr[7:2], 2'd3}], ref_mem[{addr[7:2], 2'd2}],
                       ref_mem[{addr[7:2], 2'd1}], ref_mem[{addr[7:2], 2'd0}]} : uart_val;
      v = word >> (8 * (addr % 4));
      if (nb == 1)      exp_rd = (uns || !v[7])  ? (v & 32'hFF)   : (v | 32'hFFFFFF00);
      else if (nb == 2) exp_rd = (uns || !v[15]) ? (v & 32'hFFFF) : (v | 32'hFFFF0000);
      else              exp_rd = v;
    end
    exp_wd = (nb == 1) ? (wdata & 32'hFF) * 32'h01010101 :
             (nb == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
    if (!fault && we && is_ram)
      for (int k = 0; k < nb; k++) ref_mem[8'(addr[7:0] + k)] = wdata[8*k +: 8];

    @(negedge clk);
    chk("ready_idle", bus.lsu_ready_o, 1);
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = we; bus.lsu_addr_i = addr;
    bus.lsu_wdata_i = wdata; bus.lsu_size_i = size; bus.lsu_unsigned_i = uns;
    @(posedge clk); #1;
    bus.lsu_req_i = 1'b0; bus.lsu_we_i = $urandom; bus.lsu_addr_i = $urandom;
    bus.lsu_wdata_i = $urandom; bus.lsu_size_i = $urandom; bus.lsu_unsigned_i = $urandom;
    n = 1; nonseq = 0; selcnt = 0; got = 1'b0;
    while (!got && n <= 30) begin
      if (bus.HTRANS == 2'b10) begin
        nonseq++;
        chk("haddr", bus.HADDR, addr);
        chk("hwrite", bus.HWRITE, we);
        chk("hsize", bus.HSIZE, {1'b0, size});
        chk("hsel", {bus.HSEL_UART, bus.HSEL_RAM}, {is_uart, is_ram});
      end
      if (bus.HSEL_RAM || bus.HSEL_UART) selcnt++;
      if (bus.lsu_valid_o) got = 1'b1;
      else begin
        if (!fault && n >= 2) chk("hready", bus.HREADY, (n - 2) >= waits);
        if (!fault && we && n == 2) chk("hwdata", bus.HWDATA, exp_wd);
        @(posedge clk); #1;
        n++;
      end
    end
    chk("latency", n, fault ? 2 : 3 + waits);
    chk("ready_resp", bus.lsu_ready_o, 1);
    chk("err", bus.lsu_err_o, fault || (is_uart && uerr));
    if (fault || !(is_uart && uerr)) chk("rdata", bus.lsu_rdata_o, exp_rd);
    chk("nonseq_cnt", nonseq, fault ? 0 : 1);
    chk("hsel_cnt", selcnt, fault ? 0 : 1);
    chk("hburst", bus.HBURST, 0);
  endtask

  initial begin
    int v;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(8'(i));
    bus.lsu_req_i = 1'b0; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = '0;
    bus.lsu_wdata_i = '0; bus.lsu_size_i = '0; bus.lsu_unsigned_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.lsu_ready_o, 0);
    chk("rst_htrans", bus.HTRANS, 0);
    chk("rst_hready", bus.HREADY, 1);
    chk("rst_valid", bus.lsu_valid_o, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", bus.lsu_ready_o, 1);
    chk("post_rst_haddr", bus.HADDR, 0);
    chk("post_rst_hsel", {bus.HSEL_UART, bus.HSEL_RAM}, 0);
    chk("post_rst_hwdata", bus.HWDATA, 0);
    chk("post_rst_rsp", {bus.lsu_err_o, bus.lsu_rdata_o}, 0);

    run(1, 32'h0000_0010, 32'hDEADBEEF, 2, 0, 0, 0);
    run(0, 32'h0000_0010, 32'h0, 2, 0, 0, 0);
    chk("word_load_value", bus.lsu_rdata_o, 32'hDEADBEEF);
    run(1, 32'h0000_0012, 32'h0000_8001, 1, 0, 0, 0);
    run(0, 32'h0000_0013, 32'h0, 0, 0, 0, 0);
    chk("byte_signed", bus.lsu_rdata_o, 32'hFFFFFF80);
    run(0, 32'h0000_0013, 32'h0, 0, 1, 0, 0);
    chk("byte_unsigned", bus.lsu_rdata_o, 32'h00000080);
    run(0, 32'h0000_0012, 32'h0, 1, 0, 0, 0);
    chk("half_signed", bus.lsu_rdata_o, 32'hFFFF8001);
    run(1, 32'h4000_0000, 32'h1234_5678, 2, 0, 3, 0);
    run(0, 32'h4000_0004, 32'h0, 2, 0, 1, 1);
    run(0, 32'h0000_0002, 32'h0, 2, 0, 0, 0);
    run(0, 32'h8000_0000, 32'h0, 2, 0, 0, 0);
    run(0, 32'h0000_0011, 32'h0, 1, 0, 0, 0);
    run(1, 32'h0000_0020, 32'h0, 3, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        ue;
      int          w, r, nb;
      r  = $urandom_range(0, 9);
      v  = $urandom_range(0, 9);
      sz = (v == 9) ? 2'd3 : 2'(v % 3);
      a  = {(r < 6) ? 4'h0 : (r < 9) ? 4'h4 : 4'h8, 20'h0, 8'($urandom)};
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 4) != 0) a = a - (a % nb);
      ue = (r >= 6 && r < 9) && ($urandom_range(0, 3) == 0);
      w  = $urandom_range(0, 3);
      if (ue && w == 0) w = 1;
      run($urandom_range(0, 1) == 1, a, $urandom, sz, $urandom_range(0, 1) == 1, w, ue);
    end

    // Reset while the RAM is stalling the data phase.
    cfg_waits = 5; cfg_err = 1'b0;
    @(negedge clk);
    bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 32'h0000_0020;
    bus.lsu_size_i = 2'd2; bus.lsu_unsigned_i = 1'b0;
    @(posedge clk); #1;
    bus.lsu_req_i = 1'b0;
    @(posedge clk); #1;
    chk("stall_hready", bus.HREADY, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_htrans", bus.HTRANS, 0);
    chk("midrst_hready", bus.HREADY, 1);
    chk("midrst_valid", bus.lsu_valid_o, 0);
    chk("midrst_ready", bus.lsu_ready_o, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_rel", bus.lsu_ready_o, 1);
    v = 0;
    repeat (6) begin
      if (bus.lsu_valid_o) v++;
      @(posedge clk); #1;
    end
    chk("midrst_no_valid", v, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
